// File: rtl/mx_prd_acc.sv
// Block accumulator for MX dot products: sums blk_size signed fixed-point
// products and presents each completed block sum through a valid/ready output.
module mx_prd_acc #(
    parameter int exp_width = 5,
    parameter int man_width = 2,
    parameter int prd_width = 2 * ((1 << exp_width) + man_width),
    parameter int blk_size  = 32,
    parameter int acc_width = prd_width + $clog2(blk_size)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [prd_width-1:0] i_prd,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic                 i_flush,
    output logic [acc_width-1:0] o_sum,
    output logic                 o_valid,
    input  logic                 i_ready
);

    localparam int unsigned cnt_width = $clog2(blk_size);
    localparam int unsigned ext_width = acc_width - prd_width;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t               state;
    logic [acc_width-1:0] acc;
    logic [cnt_width-1:0] cnt;
    logic [acc_width-1:0] prd_ext;
    logic [acc_width-1:0] acc_next;
    logic                 take;
    logic                 blk_final;
    logic                 drain;

    // A flushed cycle never counts as an accept, even with o_ready high.
    assign o_ready   = !o_valid || i_ready;
    assign take      = i_valid && o_ready && !i_flush;
    assign blk_final = take && (cnt == cnt_width'(blk_size - 1));
    assign drain     = o_valid && i_ready;
    assign prd_ext   = {{ext_width{i_prd[prd_width-1]}}, i_prd};
    assign acc_next  = acc + prd_ext;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= '0;
            o_sum   <= '0;
            o_valid <= 1'b0;
        end else begin
            if (i_flush) begin
                acc <= '0;
                cnt <= '0;
            end else if (take) begin
                cnt <= cnt + cnt_width'(1);
                acc <= blk_final ? '0 : acc_next;
            end

            if (blk_final) begin
                o_sum <= acc_next;
            end

            // Output register follows the state; a drain coinciding with a
            // block-final accept keeps HOLD for back-to-back blocks.
            case (state)
                ACCUM: begin
                    if (blk_final) begin
                        state   <= HOLD;
                        o_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (drain && !blk_final) begin
                        state   <= ACCUM;
                        o_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= ACCUM;
                    o_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mx_prd_acc.sv
// Scoreboard bench for mx_prd_acc: directed blocks with hand-computed sums,
// checked by an independent output monitor.
module tb_mx_prd_acc;

    localparam int PW = 68;
    localparam int AW = 73;

    logic          clk;
    logic          rst;
    logic [PW-1:0] prd;
    logic          valid_in;
    logic          ready_out;
    logic          flush;
    logic [AW-1:0] sum;
    logic          valid_out;
    logic          ready_in;

    mx_prd_acc dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_prd   (prd),
        .i_valid (valid_in),
        .o_ready (ready_out),
        .i_flush (flush),
        .o_sum   (sum),
        .o_valid (valid_out),
        .i_ready (ready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] exp_q[$];
    int            t_q[$];
    int            compared = 0;
    int            mismatched = 0;
    int            stalls = 0;

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: each drain (o_valid && i_ready before an edge) pops one expected sum.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && valid_out && ready_in) begin
                t_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_output: got %0h, required none", sum);
                end else begin
                    check("block_sum", sum, exp_q.pop_front());
                end
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the accept edge.
    task automatic send(input logic [PW-1:0] p);
        bit ok;
        ok = 1'b0;
        valid_in = 1'b1;
        prd = p;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (ready_out) ok = 1'b1;
            else stalls++;
            @(posedge clk);
            #1;
        end
        if (!ok) check("send_timeout", 1, 0);
        valid_in = 1'b0;
    endtask

    task automatic send_n(input int n, input logic [PW-1:0] p);
        for (int i = 0; i < n; i++) send(p);
    endtask

    logic [PW-1:0] pmax;
    logic [PW-1:0] pmin;
    logic [AW-1:0] neg16;

    initial begin
        rst = 1'b1;
        prd = '0;
        valid_in = 1'b0;
        flush = 1'b0;
        ready_in = 1'b1;
        pmax = {1'b0, {(PW-1){1'b1}}};
        pmin = {1'b1, {(PW-1){1'b0}}};
        neg16 = '1;
        neg16[3:0] = 4'h0;

        // Reset state, observed while reset is still asserted.
        #12;
        check("rst_ready", AW'(ready_out), AW'(1));
        check("rst_valid", AW'(valid_out), AW'(0));
        check("rst_sum", sum, AW'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // 32 ones: o_valid high exactly one cycle, one edge after the last accept.
        exp_q.push_back(AW'(32));
        send_n(31, PW'(1));
        check("pre_final_valid", AW'(valid_out), AW'(0));
        send(PW'(1));
        check("valid_after_final", AW'(valid_out), AW'(1));
        @(posedge clk);
        #1;
        check("valid_one_cycle", AW'(valid_out), AW'(0));

        // Full-range alternating extremes: 16 * (-1) = -16.
        exp_q.push_back(neg16);
        for (int i = 0; i < 16; i++) begin
            send(pmax);
            send(pmin);
        end
        @(posedge clk);
        #1;

        // Backpressure: 0+1+..+31 = 496 held 5 cycles, then 32 twos = 64.
        ready_in = 1'b0;
        exp_q.push_back(AW'(496));
        exp_q.push_back(AW'(64));
        for (int i = 0; i < 32; i++) send(PW'(i));
        fork
            send_n(32, PW'(2));
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("stall_ready", AW'(ready_out), AW'(0));
                    check("stall_sum", sum, AW'(496));
                    check("stall_valid", AW'(valid_out), AW'(1));
                    @(posedge clk);
                end
                #1 ready_in = 1'b1;
            end
        join
        @(posedge clk);
        #1;

        // Continuous stream of 96 threes: three sums of 96, 32 cycles apart.
        stalls = 0;
        t_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(AW'(96));
        send_n(96, PW'(3));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("stream_stalls", AW'(stalls), AW'(0));
        check("stream_results", AW'(t_q.size()), AW'(3));
        if (t_q.size() == 3) begin
            check("stream_gap0", AW'(t_q[1] - t_q[0]), AW'(32));
            check("stream_gap1", AW'(t_q[2] - t_q[1]), AW'(32));
        end

        // Flush after 10 fives discards the partial block and the flushed input.
        exp_q.push_back(AW'(32));
        send_n(10, PW'(5));
        flush = 1'b1;
        valid_in = 1'b1;
        prd = PW'(5);
        @(posedge clk);
        #1;
        flush = 1'b0;
        valid_in = 1'b0;
        send_n(32, PW'(1));
        @(posedge clk);
        #1;

        // Asynchronous reset mid-cycle after 20 accepts; o_sum still holds 32.
        send_n(20, PW'(1));
        #3 rst = 1'b1;
        #1;
        check("async_rst_valid", AW'(valid_out), AW'(0));
        check("async_rst_sum", sum, AW'(0));
        check("async_rst_ready", AW'(ready_out), AW'(1));
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.push_back(AW'(32));
        send_n(32, PW'(1));

        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        check("scoreboard_empty", AW'(exp_q.size()), AW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
